// File: rtl/attempt_lockout.sv
// Attempt supervisor for the combination lock: times out stalled entries,
// counts consecutive failures and holds a tick-counted lockout.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no entry in progress, tick generator stopped
//   ENTRY   | digits being entered, idle ticks counted toward timeout
//   LOCKOUT | too many failures, inputs ignored until remaining reaches 0
module attempt_lockout #(
    parameter int unsigned MAX_FAILS     = 3,
    parameter int unsigned LOCKOUT_TICKS = 40,
    parameter int unsigned ENTRY_TICKS   = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       keyActivity,
    input  logic       attemptPass,
    input  logic       attemptFail,
    output logic       tickRun,
    output logic       tickClear,
    output logic       locked,
    output logic       entryTimeout,
    output logic       lockoutDone,
    output logic [3:0] failCount,
    output logic [7:0] remaining
);

    localparam logic [3:0] FAIL_MAX   = 4'(MAX_FAILS);
    localparam logic [4:0] FAIL_LIMIT = 5'(MAX_FAILS);
    localparam logic [7:0] LOCK_LOAD  = 8'(LOCKOUT_TICKS);
    localparam logic [7:0] ENTRY_LAST = 8'(ENTRY_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTRY   = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] idle_ticks, idle_ticks_nxt;
    logic [3:0] fail_count_nxt;
    logic [7:0] remaining_nxt;
    logic       clear_nxt;
    logic       timeout_nxt;
    logic       done_nxt;
    logic       fail_event;
    logic       pass_event;

    // Next-state and next-output decode; verdicts outrank key presses and ticks.
    always_comb begin
        state_nxt      = state;
        idle_ticks_nxt = idle_ticks;
        fail_count_nxt = failCount;
        remaining_nxt  = remaining;
        clear_nxt      = 1'b0;
        timeout_nxt    = 1'b0;
        done_nxt       = 1'b0;
        fail_event     = 1'b0;
        pass_event     = 1'b0;

        case (state)
            IDLE, ENTRY: begin
                if (attemptFail) begin
                    fail_event = 1'b1;
                end else if (attemptPass) begin
                    pass_event = 1'b1;
                end else if (keyActivity) begin
                    // Restarting the generator re-phases ticks to the key press.
                    state_nxt      = ENTRY;
                    idle_ticks_nxt = 8'd0;
                    clear_nxt      = 1'b1;
                end else if (state == ENTRY && tick) begin
                    if (idle_ticks == ENTRY_LAST) begin
                        timeout_nxt = 1'b1;
                        fail_event  = 1'b1;
                    end else begin
                        idle_ticks_nxt = idle_ticks + 8'd1;
                    end
                end

                if (pass_event) begin
                    fail_count_nxt = 4'd0;
                    idle_ticks_nxt = 8'd0;
                    state_nxt      = IDLE;
                end

                if (fail_event) begin
                    idle_ticks_nxt = 8'd0;
                    if ({1'b0, failCount} + 5'd1 == FAIL_LIMIT) begin
                        state_nxt      = LOCKOUT;
                        remaining_nxt  = LOCK_LOAD;
                        fail_count_nxt = FAIL_MAX;
                        clear_nxt      = 1'b1;
                    end else begin
                        fail_count_nxt = failCount + 4'd1;
                        state_nxt      = IDLE;
                    end
                end
            end

            LOCKOUT: begin
                if (tick) begin
                    // <= 1 also keeps remaining from wrapping if it were ever 0.
                    if (remaining <= 8'd1) begin
                        remaining_nxt  = 8'd0;
                        fail_count_nxt = 4'd0;
                        done_nxt       = 1'b1;
                        state_nxt      = IDLE;
                    end else begin
                        remaining_nxt = remaining - 8'd1;
                    end
                end
            end

            default: begin
                state_nxt      = IDLE;
                idle_ticks_nxt = 8'd0;
                fail_count_nxt = 4'd0;
                remaining_nxt  = 8'd0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered outputs and idle counter; tickRun/locked track the next state
    // so they equal the registered state without any decode glitch.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idle_ticks   <= 8'd0;
            tickRun      <= 1'b0;
            tickClear    <= 1'b0;
            locked       <= 1'b0;
            entryTimeout <= 1'b0;
            lockoutDone  <= 1'b0;
            failCount    <= 4'd0;
            remaining    <= 8'd0;
        end else begin
            idle_ticks   <= idle_ticks_nxt;
            tickRun      <= (state_nxt != IDLE);
            tickClear    <= clear_nxt;
            locked       <= (state_nxt == LOCKOUT);
            entryTimeout <= timeout_nxt;
            lockoutDone  <= done_nxt;
            failCount    <= fail_count_nxt;
            remaining    <= remaining_nxt;
        end
    end

endmodule
